cond_logic_banked: RTL and testbench

COND_LOGIC_BANKED -- requirements
Module: cond_logic_banked

---
 rtl/cond_logic_banked_pkg.sv | 29 ++
 rtl/cond_logic_banked_cond_check.sv | 39 +++
 rtl/cond_logic_banked.sv | 130 +++++++++++++
 tb/tb_cond_logic_banked.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cond_logic_banked_pkg.sv
// rtl/cond_logic_banked_pkg.sv - condition codes, NZCV bit indices and flag_w bit indices
package cond_logic_banked_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int FW_NZ = 1;
  localparam int FW_CV = 0;

endpackage

// File: rtl/cond_logic_banked_cond_check.sv
// rtl/cond_logic_banked_cond_check.sv - combinational ARM condition-field decode against NZCV
module cond_check
  import cond_logic_banked_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_logic_banked.sv
// rtl/cond_logic_banked.sv - banked NZCV flags with conditional write gating
// Optional flag save stack enabled by macro COND_FLAG_STACK_EN.
module cond_logic_banked
  import cond_logic_banked_pkg::*;
#(
  parameter int NUM_CTX     = 2,
  parameter int STACK_DEPTH = 4,
  localparam int CTX_W = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1,
  localparam int SC_W  = $clog2(STACK_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid,
  input  logic            flush,
  input  logic [3:0]      cond,
  input  logic [3:0]      alu_flags,
  input  logic [1:0]      flag_w,
  input  logic [CTX_W-1:0] ctx_sel,
  input  logic            pcs,
  input  logic            reg_w,
  input  logic            mem_w,
  input  logic            save,
  input  logic            restore,
  output logic            pc_src,
  output logic            reg_write,
  output logic            mem_write,
  output logic            cond_ex,
  output logic [3:0]      flags,
  output logic [SC_W-1:0] stack_cnt,
  output logic            err_ovf,
  output logic            err_unf
);

  localparam int NB = 1 << CTX_W;

  // Array sized to the full ctx_sel range; entries >= NUM_CTX stay at reset value.
  logic [3:0] bank [NB];
  logic       sel_ok;
  logic       live;
  logic       op;
  logic       pop_en;
  logic [3:0] pop_val;

  assign sel_ok = (ctx_sel <= CTX_W'(NUM_CTX - 1));
  assign flags  = bank[ctx_sel];
  assign op     = valid & ~flush;
  assign live   = op & cond_ex;

  cond_check u_cond_check (
    .cond    (cond),
    .flags   (flags),
    .cond_ex (cond_ex)
  );

  assign pc_src    = ~reset & live & pcs;
  assign reg_write = ~reset & live & reg_w;
  assign mem_write = ~reset & live & mem_w;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NB; i++) bank[i] <= 4'b0000;
    end else if (sel_ok) begin
      if (pop_en) begin
        bank[ctx_sel] <= pop_val;
      end else if (live) begin
        if (flag_w[FW_NZ]) begin
          bank[ctx_sel][FLAG_N] <= alu_flags[FLAG_N];
          bank[ctx_sel][FLAG_Z] <= alu_flags[FLAG_Z];
        end
        if (flag_w[FW_CV]) begin
          bank[ctx_sel][FLAG_C] <= alu_flags[FLAG_C];
          bank[ctx_sel][FLAG_V] <= alu_flags[FLAG_V];
        end
      end
    end
  end

`ifdef COND_FLAG_STACK_EN
  localparam int SI_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [3:0]      stk [1 << SI_W];
  logic [SC_W-1:0] cnt;
  logic [SC_W-1:0] top;
  logic            ovf_q, unf_q;
  logic            full, empty;

  assign full    = (cnt == SC_W'(STACK_DEPTH));
  assign empty   = (cnt == '0);
  assign top     = cnt - 1'b1;
  assign pop_val = stk[top[SI_W-1:0]];
  assign pop_en  = op & restore & ~save & ~empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (op) begin
      // Simultaneous save+restore is treated as a misuse and flagged as overflow.
      if (save && restore) begin
        ovf_q <= 1'b1;
      end else if (save) begin
        if (full) begin
          ovf_q <= 1'b1;
        end else begin
          stk[cnt[SI_W-1:0]] <= flags;
          cnt <= cnt + 1'b1;
        end
      end else if (restore) begin
        if (empty) unf_q <= 1'b1;
        else       cnt   <= top;
      end
    end
  end

  assign stack_cnt = cnt;
  assign err_ovf   = ovf_q;
  assign err_unf   = unf_q;
`else
  logic unused_stack_req;

  assign unused_stack_req = save ^ restore;
  assign pop_en    = 1'b0;
  assign pop_val   = 4'b0000;
  assign stack_cnt = '0;
  assign err_ovf   = 1'b0;
  assign err_unf   = 1'b0;
`endif

endmodule

// File: tb/tb_cond_logic_banked.sv
// tb/tb_cond_logic_banked.sv - randomized self-checking bench for cond_logic_banked
module tb_cond_logic_banked;

  logic       clk = 1'b0;
  logic       reset, valid, flush;
  logic [3:0] cond, alu_flags;
  logic [1:0] flag_w;
  logic [0:0] ctx_sel;
  logic       pcs, reg_w, mem_w, save, restore;
  logic       pc_src, reg_write, mem_write, cond_ex;
  logic [3:0] flags;
  logic [2:0] stack_cnt;
  logic       err_ovf, err_unf;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] mbank [2];
  logic [3:0] mstk [$];
  logic       movf, munf;

  always #5 clk = ~clk;

  cond_logic_banked #(.NUM_CTX(2), .STACK_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .valid(valid), .flush(flush), .cond(cond),
    .alu_flags(alu_flags), .flag_w(flag_w), .ctx_sel(ctx_sel),
    .pcs(pcs), .reg_w(reg_w), .mem_w(mem_w), .save(save), .restore(restore),
    .pc_src(pc_src), .reg_write(reg_write), .mem_write(mem_write),
    .cond_ex(cond_ex), .flags(flags), .stack_cnt(stack_cnt),
    .err_ovf(err_ovf), .err_unf(err_unf)
  );

  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      0: return z;            1: return !z;
      2: return cy;           3: return !cy;
      4: return n;            5: return !n;
      6: return v;            7: return !v;
      8: return cy && !z;     9: return !cy || z;
      10: return n == v;      11: return n != v;
      12: return !z && n == v; 13: return z || n != v;
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic f, input logic [3:0] c, input logic [3:0] a,
                       input logic [1:0] fw, input logic x, input logic p, input logic r,
                       input logic m, input logic s, input logic rs);
    reset = 1'b0; valid = v; flush = f; cond = c; alu_flags = a; flag_w = fw;
    ctx_sel = x; pcs = p; reg_w = r; mem_w = m; save = s; restore = rs;
  endtask

  // Compare combinational outputs against the model, then advance the model across one edge.
  task automatic step();
    logic ce, go;
    logic [3:0] cur, nxt;
    int exp_cnt;
    #1;
    cur = mbank[ctx_sel];
    ce  = cond_pass(cond, cur);
    go  = valid && !flush && ce && !reset;
`ifdef COND_FLAG_STACK_EN
    exp_cnt = mstk.size();
`else
    exp_cnt = 0;
`endif
    check("cond_ex",   32'(cond_ex),   32'(ce));
    check("pc_src",    32'(pc_src),    32'(go && pcs));
    check("reg_write", 32'(reg_write), 32'(go && reg_w));
    check("mem_write", 32'(mem_write), 32'(go && mem_w));
    check("flags",     32'(flags),     32'(cur));
    check("stack_cnt", 32'(stack_cnt), 32'(exp_cnt));
    check("err_ovf",   32'(err_ovf),   32'(movf));
    check("err_unf",   32'(err_unf),   32'(munf));
    if (reset) begin
      mbank[0] = 4'h0; mbank[1] = 4'h0;
      mstk.delete(); movf = 1'b0; munf = 1'b0;
    end else begin
      nxt = cur;
      if (go && flag_w[1]) nxt[3:2] = alu_flags[3:2];
      if (go && flag_w[0]) nxt[1:0] = alu_flags[1:0];
`ifdef COND_FLAG_STACK_EN
      if (valid && !flush) begin
        if (save && restore) movf = 1'b1;
        else if (save) begin
          if (mstk.size() == 4) movf = 1'b1;
          else mstk.push_back(cur);
        end else if (restore) begin
          if (mstk.size() == 0) munf = 1'b1;
          else nxt = mstk.pop_back();
        end
      end
`endif
      mbank[ctx_sel] = nxt;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(0, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    step();
  endtask

  initial begin
    mbank[0] = 4'h0; mbank[1] = 4'h0; movf = 1'b0; munf = 1'b0;
    drive(0, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    do_reset();

    // Reset state: EQ fails, AL passes
    drive(1, 0, 4'h0, 4'h0, 2'b00, 0, 1, 0, 0, 0, 0);
    #1;
    check("rst_eq_cond_ex", 32'(cond_ex), 32'd0);
    check("rst_eq_pc_src", 32'(pc_src), 32'd0);
    step();
    drive(1, 0, 4'hE, 4'h0, 2'b00, 0, 1, 1, 1, 0, 0);
    #1;
    check("al_pc_src", 32'(pc_src), 32'd1);
    step();

    // Flag writes in ctx 0, then partial NZ-only write
    drive(1, 0, 4'hE, 4'hF, 2'b11, 0, 0, 0, 0, 0, 0);
    step();
    check("flags_1111", 32'(flags), 32'hF);
    drive(1, 0, 4'hE, 4'h0, 2'b10, 0, 0, 0, 0, 0, 0);
    step();
    check("flags_0011", 32'(flags), 32'h3);

    // Bank independence
    do_reset();
    drive(1, 0, 4'hE, 4'h4, 2'b11, 1, 0, 0, 0, 0, 0);
    step();
    drive(1, 0, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0);
    #1;
    check("ctx0_flags", 32'(flags), 32'h0);
    check("ctx0_eq", 32'(cond_ex), 32'd0);
    step();
    drive(1, 0, 4'h0, 4'h0, 2'b00, 1, 0, 0, 0, 0, 0);
    #1;
    check("ctx1_eq", 32'(cond_ex), 32'd1);
    step();

    // Flush and NV block everything
    drive(1, 1, 4'hE, 4'hA, 2'b11, 0, 1, 1, 1, 0, 0);
    #1;
    check("flush_we", 32'({pc_src, reg_write, mem_write}), 32'd0);
    step();
    check("flush_flags", 32'(flags), 32'h0);
    drive(1, 0, 4'hF, 4'hA, 2'b11, 0, 1, 1, 1, 0, 0);
    step();
    check("nv_flags", 32'(flags), 32'h0);

    // Back-to-back: second instruction sees first's write
    drive(1, 0, 4'hE, 4'h4, 2'b10, 0, 0, 0, 0, 0, 0);
    step();
    drive(1, 0, 4'h0, 4'h0, 2'b00, 0, 1, 0, 0, 0, 0);
    #1;
    check("b2b_pc_src", 32'(pc_src), 32'd1);
    step();

`ifdef COND_FLAG_STACK_EN
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 4'hE, 4'(i + 1), 2'b11, 0, 0, 0, 0, 1, 0);
      step();
    end
    check("ovf_cnt", 32'(stack_cnt), 32'd4);
    check("ovf_flag", 32'(err_ovf), 32'd1);
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 0, 1);
      step();
      check("lifo_flags", 32'(flags), 32'((i < 4) ? 3 - i : 0));
    end
    check("unf_flag", 32'(err_unf), 32'd1);

    do_reset();
    drive(1, 0, 4'hE, 4'h9, 2'b11, 0, 0, 0, 0, 0, 0);
    step();
    drive(1, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 1, 0);
    step();
    drive(1, 0, 4'hE, 4'h6, 2'b11, 0, 0, 0, 0, 0, 1);
    step();
    check("pop_over_fw", 32'(flags), 32'h9);
    drive(1, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 1, 0);
    step();
    drive(1, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 1, 1);
    step();
    check("both_cnt", 32'(stack_cnt), 32'd1);
    check("both_ovf", 32'(err_ovf), 32'd1);
`endif

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 1), 4'($urandom),
            4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), ($urandom_range(0, 9) < 2), ($urandom_range(0, 9) < 2));
      if ($urandom_range(0, 99) < 2) reset = 1'b1;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
